core_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32I core.
- Fetches each instruction over a req/ack instruction-memory port and presents it to the decode stage.
- Steps the datapath through decode, execute, optional memory access and writeback.
- Owns the program counter.
- Drives memory requests and the register-file write strobe. It is the only block that advances `pc`.

---
 rtl/rv_pkg.sv | 28 ++
 rtl/perf_cnt.sv | 21 ++
 rtl/core_seq_ctrl.sv | 108 ++++++++++
 tb/tb_core_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I opcode constants, sequencer state encoding and opcode classifiers
// Imported by the sequencer and by the decode stage so both agree on the opcode map.
package rv_pkg;
    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LUI    = 7'b0110111;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} seq_state_t;

    function automatic logic is_legal(input logic [6:0] op);
        return op inside {R_TYPE, I_TYPE, LOAD, STORE, BRANCH, JALR, JAL, AUIPC, LUI};
    endfunction

    function automatic logic is_mem(input logic [6:0] op);
        return op inside {LOAD, STORE};
    endfunction

    // Everything legal writes rd except stores and branches.
    function automatic logic writes_rd(input logic [6:0] op);
        return is_legal(op) && !(op inside {STORE, BRANCH});
    endfunction
endpackage

// File: rtl/perf_cnt.sv
// perf_cnt: free-running cycle and retired-instruction counters, both wrapping at 2^32
// Ports: clk/rst (sync, active-high); i_cyc_en/i_ret_en increment enables;
//        o_cycle_cnt/o_instret counter values.
module perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cyc_en,
    input  logic        i_ret_en,
    output logic [31:0] o_cycle_cnt,
    output logic [31:0] o_instret
);
    always_ff @(posedge clk) begin
        if (rst) begin
            o_cycle_cnt <= '0;
            o_instret   <= '0;
        end else begin
            o_cycle_cnt <= o_cycle_cnt + 32'(i_cyc_en);
            o_instret   <= o_instret + 32'(i_ret_en);
        end
    end
endmodule

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle RV32I sequencer (FETCH/DECODE/EXEC/MEM/WB/HALT), owns the PC
// Ports: clk, rst (sync, active-high); pc/instr to decode; imem_req/addr/ack/rdata fetch port;
//        br_taken/tgt_addr redirect from datapath; dmem_req/we/ack data port; rf_we write strobe;
//        illegal sticky flag; cycle_cnt/instret performance counters.
// Define CORE_PERF_CNT_EN to build the counters; otherwise both counter ports read 0.
module core_seq_ctrl
    import rv_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    input  logic            br_taken,
    input  logic [PC_W-1:0] tgt_addr,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            rf_we,
    output logic            illegal,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     instret
);
    seq_state_t      r_state;
    logic            r_redir;
    logic [PC_W-1:0] r_tgt_q;
    logic [6:0]      w_op;

    assign w_op      = instr[6:0];
    assign imem_addr = pc;

    // Requests are registered: raised on entry to FETCH/MEM (or one cycle after reset),
    // dropped on the edge that samples the ack, so they fall the cycle after the ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= FETCH;
            pc       <= RESET_PC;
            instr    <= '0;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            rf_we    <= 1'b0;
            illegal  <= 1'b0;
            r_redir  <= 1'b0;
            r_tgt_q  <= '0;
        end else begin
            rf_we <= 1'b0;
            case (r_state)
                FETCH: begin
                    if (imem_req && imem_ack) begin
                        instr    <= imem_rdata;
                        imem_req <= 1'b0;
                        r_state  <= DECODE;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                DECODE: begin
                    illegal <= !is_legal(w_op);
                    r_state <= is_legal(w_op) ? EXEC : HALT;
                end
                EXEC: begin
                    r_redir  <= br_taken;
                    r_tgt_q  <= tgt_addr & ~PC_W'(3);
                    dmem_req <= is_mem(w_op);
                    dmem_we  <= w_op == STORE;
                    rf_we    <= !is_mem(w_op) && writes_rd(w_op);
                    r_state  <= is_mem(w_op) ? MEM : WB;
                end
                MEM: begin
                    if (dmem_req && dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        rf_we    <= writes_rd(w_op);
                        r_state  <= WB;
                    end
                end
                WB: begin
                    pc       <= r_redir ? r_tgt_q : pc + PC_W'(4);
                    imem_req <= 1'b1;
                    r_state  <= FETCH;
                end
                HALT: r_state <= HALT;
                default: r_state <= HALT;
            endcase
        end
    end

`ifdef CORE_PERF_CNT_EN
    perf_cnt u_perf_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_cyc_en    (r_state != HALT),
        .i_ret_en    (r_state == WB),
        .o_cycle_cnt (cycle_cnt),
        .o_instret   (instret)
    );
`else
    assign cycle_cnt = '0;
    assign instret   = '0;
`endif
endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl: directed vectors with a queue scoreboard for fetch addresses, data writes and rf writes
module tb_core_seq_ctrl;
`ifdef CORE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc, imem_addr, tgt_addr = '0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0, instr;
    logic        br_taken = 1'b0;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0, rf_we, illegal;
    logic [31:0] cycle_cnt, instret;

    int checks = 0;
    int failures = 0;
    int cyc;

    logic [15:0] q_fetch[$];
    logic        q_dmem[$];
    logic [15:0] q_rf[$];

    typedef struct {
        logic [31:0] w;
        logic [15:0] at, nxt;
        int          iw, dw;
        logic        br;
        logic [15:0] tgt;
        bit          mem, we, wr;
        int          lat;
    } vec_t;

    core_seq_ctrl dut (
        .clk(clk), .rst(rst), .pc(pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .br_taken(br_taken), .tgt_addr(tgt_addr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_we(rf_we), .illegal(illegal), .cycle_cnt(cycle_cnt), .instret(instret)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every handshake or write strobe the DUT presents consumes one expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req && imem_ack) begin
                if (q_fetch.size() == 0) chk("fetch_unexpected", 1, 0);
                else chk("fetch_addr", 32'(imem_addr), 32'(q_fetch.pop_front()));
            end
            if (dmem_req && dmem_ack) begin
                if (q_dmem.size() == 0) chk("dmem_unexpected", 1, 0);
                else chk("dmem_we", 32'(dmem_we), 32'(q_dmem.pop_front()));
            end
            if (rf_we) begin
                if (q_rf.size() == 0) chk("rf_we_unexpected", 1, 0);
                else chk("rf_we_pc", 32'(pc), 32'(q_rf.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20 && !imem_req; i++) step();
        chk("imem_req_seen", 32'(imem_req), 1);
    endtask

    function automatic vec_t mk(input logic [31:0] w, input logic [15:0] at, input logic [15:0] nxt,
                                input int iw, input int dw, input logic br, input logic [15:0] tgt,
                                input bit mem, input bit we, input bit wr, input int lat);
        vec_t v;
        v.w = w; v.at = at; v.nxt = nxt; v.iw = iw; v.dw = dw; v.br = br; v.tgt = tgt;
        v.mem = mem; v.we = we; v.wr = wr; v.lat = lat;
        return v;
    endfunction

    // br_taken is held high with junk targets outside DECODE/EXEC; only the EXEC sample may matter.
    task automatic run(input vec_t v);
        int t0;
        int n;
        br_taken = 1'b1;
        tgt_addr = 16'h1234;
        wait_req();
        t0 = cyc;
        repeat (v.iw) step();
        imem_ack = 1'b1;
        imem_rdata = v.w;
        q_fetch.push_back(v.at);
        if (v.wr) q_rf.push_back(v.at);
        step();
        imem_ack = 1'b0;
        chk("imem_req_drop", 32'(imem_req), 0);
        br_taken = v.br;
        tgt_addr = v.tgt;
        step();
        step();
        br_taken = 1'b1;
        tgt_addr = 16'h2222;
        if (v.mem) begin
            q_dmem.push_back(v.we);
            n = 0;
            repeat (v.dw) begin
                n += int'(dmem_req);
                step();
            end
            dmem_ack = 1'b1;
            n += int'(dmem_req);
            step();
            dmem_ack = 1'b0;
            chk("dmem_req_cycles", n, v.dw + 1);
            chk("dmem_req_drop", 32'(dmem_req), 0);
        end
        step();
        br_taken = 1'b0;
        chk("latency", cyc - t0, v.lat);
        chk("pc_next", 32'(pc), 32'(v.nxt));
    endtask

    initial begin
        vec_t vecs[$];
        int   n;
        vecs.push_back(mk(32'h0000A103, 16'h0004, 16'h0008, 0, 3, 1'b0, 16'h0000, 1, 0, 1, 8));
        vecs.push_back(mk(32'h0020A023, 16'h0008, 16'h000C, 0, 0, 1'b0, 16'h0000, 1, 1, 0, 5));
        vecs.push_back(mk(32'h00000063, 16'h000C, 16'h0040, 0, 0, 1'b1, 16'h0042, 0, 0, 0, 4));
        vecs.push_back(mk(32'h00500093, 16'h0040, 16'h0044, 2, 0, 1'b0, 16'h0000, 0, 0, 1, 6));
        vecs.push_back(mk(32'h0000006F, 16'h0044, 16'hFFFC, 0, 0, 1'b1, 16'hFFFF, 0, 0, 1, 4));
        vecs.push_back(mk(32'h000010B7, 16'hFFFC, 16'h0000, 0, 0, 1'b0, 16'h0000, 0, 0, 1, 4));

        repeat (3) step();
        chk("rst_pc", 32'(pc), 0);
        chk("rst_instr", instr, 0);
        chk("rst_imem_req", 32'(imem_req), 0);
        chk("rst_dmem_req", 32'(dmem_req), 0);
        chk("rst_rf_we", 32'(rf_we), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_cycle_cnt", cycle_cnt, 0);
        chk("rst_instret", instret, 0);

        rst = 1'b0;
        chk("c0_imem_req", 32'(imem_req), 0);
        step();
        chk("c1_imem_req", 32'(imem_req), 1);
        imem_ack = 1'b1;
        imem_rdata = 32'h00500093;
        q_fetch.push_back(16'h0000);
        q_rf.push_back(16'h0000);
        step();
        imem_ack = 1'b0;
        chk("c2_imem_req", 32'(imem_req), 0);
        chk("c2_instr", instr, 32'h00500093);
        step();
        chk("c3_rf_we", 32'(rf_we), 0);
        step();
        chk("c4_rf_we", 32'(rf_we), 1);
        step();
        chk("c5_rf_we", 32'(rf_we), 0);
        chk("c5_pc", 32'(pc), 4);

        foreach (vecs[i]) run(vecs[i]);

        wait_req();
        imem_ack = 1'b1;
        imem_rdata = 32'h0000A103;
        q_fetch.push_back(16'h0000);
        step();
        imem_ack = 1'b0;
        step();
        step();
        chk("mem_dmem_req", 32'(dmem_req), 1);
        rst = 1'b1;
        step();
        chk("rstmem_dmem_req", 32'(dmem_req), 0);
        rst = 1'b0;
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("rstmem_imem_req", 32'(imem_req), 1);
        chk("rstmem_dmem_req2", 32'(dmem_req), 0);
        chk("rstmem_rf_we", 32'(rf_we), 0);
        chk("rstmem_pc", 32'(pc), 0);
        chk("rstmem_instret", instret, 0);
        chk("rstmem_cycle_cnt", cycle_cnt, PERF ? 1 : 0);

        rst = 1'b1;
        step();
        chk("rstfetch_imem_req", 32'(imem_req), 0);
        rst = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        step();
        imem_ack = 1'b0;
        chk("rstfetch_req_again", 32'(imem_req), 1);
        chk("rstfetch_instr", instr, 0);

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++)
            run(mk(32'h00108093, 16'(4 * i), 16'(4 * i + 4), 0, 0, 1'b0, 16'h0000, 0, 0, 1, 4));
        chk("perf_instret", instret, PERF ? 10 : 0);
        chk("perf_cycle_cnt", cycle_cnt, PERF ? 41 : 0);

        wait_req();
        imem_ack = 1'b1;
        imem_rdata = 32'h0000007F;
        q_fetch.push_back(16'd40);
        step();
        imem_ack = 1'b0;
        step();
        chk("halt_illegal", 32'(illegal), 1);
        n = 0;
        repeat (20) begin
            n += int'(imem_req) + int'(dmem_req) + int'(rf_we);
            step();
        end
        chk("halt_activity", n, 0);
        chk("halt_illegal_sticky", 32'(illegal), 1);
        chk("halt_cycle_cnt", cycle_cnt, PERF ? 43 : 0);
        chk("halt_instret", instret, PERF ? 10 : 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("recover_pc", 32'(pc), 0);
        chk("recover_illegal", 32'(illegal), 0);
        chk("recover_imem_req", 32'(imem_req), 0);
        step();
        chk("recover_imem_req_rise", 32'(imem_req), 1);

        chk("q_fetch_empty", q_fetch.size(), 0);
        chk("q_dmem_empty", q_dmem.size(), 0);
        chk("q_rf_empty", q_rf.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
